// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: grant encoding and access-size codes shared by the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_e;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
endpackage

// File: rtl/arb_streak_counter.sv
// arb_streak_counter: saturating count of consecutive CPU wins while debug waits
module arb_streak_counter #(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam logic [3:0] MAX = 4'(MAX_CPU_STREAK);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != MAX) ? cnt + 4'd1 : cnt;
  assign at_limit = cnt == MAX;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU load/store path and a debug master
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_func3,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [2:0]        dbg_func3,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_extract,
  output logic              mem_store,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
);
  gnt_e gnt;
  logic cpu_req, cpu_g, dbg_g, cpu_load, dbg_load, at_limit;
  assign cpu_req = cpu_rd | cpu_wr;
  assign gnt = !reset ? GNT_NONE
             : (dbg_valid && (dbg_lock || at_limit)) ? GNT_DBG
             : cpu_req ? GNT_CPU
             : dbg_valid ? GNT_DBG
             : GNT_NONE;
  assign cpu_g = gnt == GNT_CPU;
  assign dbg_g = gnt == GNT_DBG;
  // a simultaneous store wins over the load
  assign cpu_load = cpu_g & cpu_rd & ~cpu_wr;
  assign dbg_load = dbg_g & ~dbg_we;
  assign mem_store   = (cpu_g & cpu_wr) | (dbg_g & dbg_we);
  assign mem_extract = cpu_load | dbg_load;
  assign mem_addr  = cpu_g ? cpu_addr  : dbg_g ? dbg_addr  : '0;
  assign mem_wdata = cpu_g ? cpu_wdata : dbg_g ? dbg_wdata : '0;
  assign mem_func3 = cpu_g ? cpu_func3 : dbg_g ? dbg_func3 : '0;
  assign cpu_stall = reset & cpu_req & ~cpu_g;
  assign cpu_rdata = cpu_load ? mem_rdata : '0;
  assign dbg_ready = dbg_g;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_load;
      if (dbg_load) dbg_rdata <= mem_rdata;
    end
  arb_streak_counter #(.MAX_CPU_STREAK(MAX_CPU_STREAK)) u_streak (
    .clk      (clk),
    .reset    (reset),
    .inc      (cpu_g & dbg_valid),
    .clr      (dbg_g | ~dbg_valid),
    .at_limit (at_limit)
  );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a small word memory behind the arbitrated port
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, dbg_valid, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [2:0]  cpu_func3, dbg_func3;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ready, dbg_rvalid, mem_extract, mem_store;
  logic [2:0]  mem_func3;
  logic [31:0] mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_CPU_STREAK(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_extract(mem_extract), .mem_store(mem_store), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_store) mem[mem_addr[7:2]] <= mem_wdata;

  // scoreboard: expected debug read data queued at acceptance, retired on dbg_rvalid
  always @(posedge clk) if (dbg_ready && !dbg_we) exp_q.push_back(mem[dbg_addr[7:2]]);
  always @(negedge reset) exp_q.delete();
  always @(negedge clk) if (reset) begin
    checks++;
    if (dbg_rvalid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL sb_rvalid got=%b exp=%b", dbg_rvalid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dbg_rdata !== exp_v) begin
        failures++;
        $display("FAIL sb_rdata got=%h exp=%h", dbg_rdata, exp_v);
      end
    end
  end

  task idle_in;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_func3 = 3'b010;
    dbg_valid = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0; dbg_func3 = 3'b010;
  endtask

  task test_reset;
    idle_in();
    reset = 0;
    cpu_rd = 1; cpu_addr = 32'h10; dbg_valid = 1;
    @(negedge clk); #1;
    checks++; if ({mem_store, mem_extract, cpu_stall, dbg_ready} !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {mem_store, mem_extract, cpu_stall, dbg_ready}); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rst_cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++; if ({dbg_rvalid, dbg_rdata} !== 33'h0) begin failures++; $display("FAIL rst_dbg_resp got=%b/%h exp=0/0", dbg_rvalid, dbg_rdata); end
    checks++; if (dut.u_streak.cnt !== 4'd0) begin failures++; $display("FAIL rst_streak got=%0d exp=0", dut.u_streak.cnt); end
    idle_in();
    @(negedge clk); reset = 1;
  endtask

  task test_dbg_write;
    logic [31:0] a [3];
    logic [31:0] d [3];
    a = '{32'h20, 32'h10, 32'h40};
    d = '{32'h55, 32'hDEADBEEF, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_in(); dbg_valid = 1; dbg_we = 1; dbg_addr = a[i]; dbg_wdata = d[i];
      #1;
      checks++; if ({dbg_ready, mem_store, mem_extract} !== 3'b110) begin failures++; $display("FAIL dw_strobes got=%b exp=110", {dbg_ready, mem_store, mem_extract}); end
      checks++; if (mem_addr !== a[i] || mem_wdata !== d[i]) begin failures++; $display("FAIL dw_bus got=%h/%h exp=%h/%h", mem_addr, mem_wdata, a[i], d[i]); end
      @(posedge clk); #1;
      checks++; if (mem[a[i][7:2]] !== d[i]) begin failures++; $display("FAIL dw_commit got=%h exp=%h", mem[a[i][7:2]], d[i]); end
    end
    @(negedge clk); idle_in();
  endtask

  task test_cpu_load;
    @(negedge clk);
    idle_in(); cpu_rd = 1; cpu_addr = 32'h10;
    #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", cpu_rdata); end
    checks++; if ({cpu_stall, mem_extract, mem_store} !== 3'b010) begin failures++; $display("FAIL ld_strobes got=%b exp=010", {cpu_stall, mem_extract, mem_store}); end
    @(posedge clk); #1;
    checks++; if (dut.u_streak.cnt !== 4'd0) begin failures++; $display("FAIL ld_streak got=%0d exp=0", dut.u_streak.cnt); end
    @(negedge clk); idle_in(); #1;
    checks++; if ({mem_addr, mem_wdata, mem_func3, mem_store, mem_extract} !== 69'h0) begin failures++; $display("FAIL idle_bus got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_func3); end
  endtask

  task test_streak;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_in(); cpu_rd = 1; cpu_addr = 32'h10; dbg_valid = c < 5; dbg_addr = 32'h40;
      #1;
      checks++; if (dut.u_streak.cnt !== 4'(c < 5 ? c : 0)) begin failures++; $display("FAIL stk_count c=%0d got=%0d exp=%0d", c, dut.u_streak.cnt, c < 5 ? c : 0); end
      checks++; if (dbg_ready !== (c == 4) || cpu_stall !== (c == 4)) begin failures++; $display("FAIL stk_grant c=%0d got=%b%b exp=%b%b", c, dbg_ready, cpu_stall, c == 4, c == 4); end
      checks++; if (mem_addr !== (c == 4 ? 32'h40 : 32'h10)) begin failures++; $display("FAIL stk_addr c=%0d got=%h", c, mem_addr); end
      if (c == 5) begin
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL stk_resp got=%b/%h exp=1/cafef00d", dbg_rvalid, dbg_rdata); end
      end
    end
    @(negedge clk); idle_in(); #1;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL stk_hold got=%b/%h exp=0/cafef00d", dbg_rvalid, dbg_rdata); end
  endtask

  task test_lock;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_in(); cpu_rd = 1; cpu_addr = 32'h10;
      dbg_valid = c < 3; dbg_lock = 1; dbg_we = 1; dbg_addr = 32'h50; dbg_wdata = 32'(c);
      #1;
      checks++; if (cpu_stall !== (c < 3) || dbg_ready !== (c < 3)) begin failures++; $display("FAIL lock_grant c=%0d got=%b%b exp=%b%b", c, cpu_stall, dbg_ready, c < 3, c < 3); end
      checks++; if (cpu_rdata !== (c == 3 ? 32'hDEADBEEF : 32'h0)) begin failures++; $display("FAIL lock_rdata c=%0d got=%h", c, cpu_rdata); end
    end
    @(negedge clk); idle_in();
  endtask

  task test_rd_wr_both;
    @(negedge clk);
    idle_in(); cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'h1234; cpu_func3 = 3'b010;
    #1;
    checks++; if ({mem_store, mem_extract, cpu_stall} !== 3'b100) begin failures++; $display("FAIL both_strobes got=%b exp=100", {mem_store, mem_extract, cpu_stall}); end
    checks++; if (cpu_rdata !== 32'h0 || mem_wdata !== 32'h1234 || mem_addr !== 32'h30) begin failures++; $display("FAIL both_bus got=%h/%h/%h", cpu_rdata, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    checks++; if (mem[12] !== 32'h1234) begin failures++; $display("FAIL both_commit got=%h exp=1234", mem[12]); end
    @(negedge clk); idle_in();
  endtask

  task test_reset_mid;
    @(negedge clk);
    idle_in(); cpu_rd = 1; cpu_addr = 32'h10; dbg_valid = 1; dbg_addr = 32'h20;
    @(posedge clk); #1;
    checks++; if (dut.u_streak.cnt !== 4'd1) begin failures++; $display("FAIL mid_streak got=%0d exp=1", dut.u_streak.cnt); end
    @(negedge clk);
    dbg_lock = 1;
    #1;
    checks++; if (dbg_ready !== 1'b1 || cpu_stall !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b%b exp=11", dbg_ready, cpu_stall); end
    #2 reset = 0;
    #1;
    checks++; if ({dbg_ready, cpu_stall, mem_extract, mem_store} !== 4'b0 || cpu_rdata !== 32'h0) begin failures++; $display("FAIL mid_forced got=%b/%h", {dbg_ready, cpu_stall, mem_extract, mem_store}, cpu_rdata); end
    checks++; if (dbg_rdata !== 32'h0 || dut.u_streak.cnt !== 4'd0) begin failures++; $display("FAIL mid_clear got=%h/%0d exp=0/0", dbg_rdata, dut.u_streak.cnt); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (dbg_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid c=%0d got=%b exp=0", c, dbg_rvalid); end
    end
    @(negedge clk); idle_in(); reset = 1;
    @(posedge clk); #1;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin failures++; $display("FAIL mid_after got=%b/%h exp=0/0", dbg_rvalid, dbg_rdata); end
  endtask

  initial begin
    test_reset();
    test_dbg_write();
    test_cpu_load();
    test_streak();
    test_lock();
    test_rd_wr_both();
    test_reset_mid();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the CPU load/store path and a debug/program-loader master. Sits between the CPU's load/store signals and the data memory: it grants one access per cycle, stalls the CPU when it loses arbitration, and caps CPU monopolisation with a streak counter so the debug master cannot starve. Memory read is combinational; memory write commits on the rising clock edge.

## Interface
- MAX_CPU_STREAK, 4: consecutive CPU grants allowed while debug is waiting; range 1–15.
- ADDR_W, 32: address width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU load request.
- cpu_wr  in  1  CPU store request.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_func3  in  3  CPU access size/sign code.
- cpu_rdata  out  32  load data, valid in the same cycle as the grant.
- cpu_stall  out  1  CPU request not granted this cycle; hold PC and inhibit register write.
- dbg_valid  in  1  debug request.
- dbg_we  in  1  debug write (1) or read (0).
- dbg_lock  in  1  debug always wins while asserted.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  32  debug write data.
- dbg_func3  in  3  debug access size code.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  registered read response strobe.
- dbg_rdata  out  32  registered read data.
- mem_extract, mem_store  out  1 each  memory strobes.
- mem_addr  out  ADDR_W; mem_wdata  out  32; mem_func3  out  3; mem_rdata  in  32.

## Operation
- Grant per cycle is combinational from the current requests and the registered streak count.
- Rules, in priority order:
  - if neither side requests: no grant.
  - dbg_valid && dbg_lock: debug wins.
  - dbg_valid && streak == MAX_CPU_STREAK: debug wins.
  - CPU request present: CPU wins.
  - otherwise, if dbg_valid: debug wins.
- Granted side drives mem_addr, mem_wdata and mem_func3. mem_store = write granted. mem_extract = read granted.
- With no grant, all strobes are 0 and mem_addr, mem_wdata and mem_func3 are 0.
- A CPU request is (cpu_rd | cpu_wr). If both are high, the store is performed and the load is ignored.
- cpu_stall = CPU request && grant != CPU. cpu_rdata = mem_rdata when the CPU read is granted, else 0.
- dbg_ready = grant == DBG. A debug request is accepted on any cycle where dbg_valid && dbg_ready. The master must hold its request fields until accepted.
- Streak counter (4 bits):
  - increments on a CPU grant while dbg_valid is high;
  - clears on any debug grant and on any cycle with dbg_valid low;
  - saturates at MAX_CPU_STREAK.
- Debug read: on acceptance, mem_rdata is registered into dbg_rdata and dbg_rvalid pulses high for exactly one cycle.
- dbg_rdata holds its last value until the next debug read.

## Timing
- Reset (reset low, asynchronous) forces: streak 0, dbg_rvalid 0, dbg_rdata 0.
- While reset is low, combinational outputs are also forced: mem strobes 0, cpu_stall 0, dbg_ready 0, cpu_rdata 0.
- CPU load: zero-latency, data in the grant cycle. CPU store: commits at the end of the grant cycle.
- Debug read: dbg_rvalid is high on the cycle after acceptance (latency 1). Back-to-back accepted reads give a continuous dbg_rvalid.
- Debug write: commits at the end of the acceptance cycle. No response strobe.
- Worst-case debug wait with dbg_lock low: MAX_CPU_STREAK cycles, then one guaranteed grant.
- Streak saturation persists only until a debug grant, so a debug grant is followed by at least one CPU grant if the CPU is requesting.
- If reset asserts mid-operation, a pending dbg_rvalid is dropped and no response is owed. The debug master must reissue.
- With dbg_lock high and dbg_valid held continuously, the CPU stalls indefinitely. This is intended for program loading.

## Structure
- Shared package `dmem_arb_pkg`:
  - grant encoding: GNT_NONE = 2'd0, GNT_CPU = 2'd1, GNT_DBG = 2'd2;
  - func3 size constants LB, LH, LW, LBU, LHU, SB, SH, SW.
- One sub-module, `arb_streak_counter`: saturating counter with increment/clear inputs and an at-limit output, parameterised by MAX_CPU_STREAK.
- Grant mux, stall logic and debug response register live in the top module.

## Test plan
- Reset released, CPU cpu_rd at 0x10 with mem_rdata = 0xDEADBEEF, no debug → cpu_rdata = 0xDEADBEEF same cycle, cpu_stall 0, streak stays 0.
- dbg_valid write 0x55 to 0x20 with CPU idle → dbg_ready 1 that cycle, mem_store 1, mem_addr 0x20; memory holds 0x55 next cycle.
- CPU continuously requesting, dbg_valid read held, MAX_CPU_STREAK = 4:
  - CPU granted cycles 0–3;
  - cycle 4: debug granted and cpu_stall 1;
  - cycle 5: dbg_rvalid 1 with captured data, CPU granted again.
- dbg_lock high, dbg_valid held 3 cycles while CPU requests → cpu_stall 1 for all 3 cycles; CPU granted on the cycle after dbg_valid drops.
- cpu_rd and cpu_wr both high at 0x30 with wdata 0x1234 → mem_store 1, mem_extract 0, cpu_rdata 0.
- Debug read accepted, reset asserted before the next edge → dbg_rvalid never asserts; dbg_rdata 0 after reset; streak 0.
